// File: rtl/fde_pkg.sv
// Shared fetch/decode/execute definitions: ID_EX and EX_MEM field bounds,
// one-hot op bit indices, execute-stage state encoding and datapath width.
// No ports; imported by ex_stage, ex_stage_if, ex_mul_iter and the decoder.
package fde_pkg;

  localparam int XLEN       = 32;
  localparam int ID_EX_W    = 176;
  localparam int EX_MEM_W   = 70;
  localparam int MUL_CYCLES = 32;

  // ID_EX packet field bounds
  localparam int ID_INSTR_LSB = 0;
  localparam int ID_INSTR_MSB = 31;
  localparam int ID_PC_LSB    = 32;
  localparam int ID_PC_MSB    = 63;
  localparam int ID_RS_LSB    = 64;
  localparam int ID_RS_MSB    = 95;
  localparam int ID_RT_LSB    = 96;
  localparam int ID_RT_MSB    = 127;
  localparam int ID_IMM_LSB   = 128;
  localparam int ID_IMM_MSB   = 159;
  localparam int ID_OP_LSB    = 160;
  localparam int ID_OP_MSB    = 175;

  // One-hot op bit indices within the op field
  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_LI   = 2;
  localparam int OP_SHL  = 3;
  localparam int OP_SHR  = 4;
  localparam int OP_AND  = 5;
  localparam int OP_OR   = 6;
  localparam int OP_XOR  = 7;
  localparam int OP_BR   = 8;
  localparam int OP_BNE  = 9;
  localparam int OP_MOV  = 10;
  localparam int OP_ADI  = 11;
  localparam int OP_MUL  = 12;
  localparam int OP_HLT  = 13;
  localparam int OP_NOP  = 14;
  localparam int OP_RSVD = 15;

  // EX_MEM packet field bounds
  localparam int EXM_RES_LSB  = 0;
  localparam int EXM_RES_MSB  = 31;
  localparam int EXM_DEST_LSB = 32;
  localparam int EXM_DEST_MSB = 36;
  localparam int EXM_WE       = 37;
  localparam int EXM_PC_LSB   = 38;
  localparam int EXM_PC_MSB   = 69;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_HALTED   = 2'd2
  } ex_state_t;

endpackage

// File: rtl/ex_stage_if.sv
// Decode->execute->writeback bundle: ID_EX packet in, EX_MEM packet, branch
// redirect, stall and halt status out. master = upstream/consumer side,
// slave = execute stage.
interface ex_stage_if
  import fde_pkg::*;
();
  logic [ID_EX_W-1:0]  id_ex;
  logic                id_ex_valid;
  logic                stall;
  logic [EX_MEM_W-1:0] ex_mem;
  logic                ex_mem_valid;
  logic                branch_taken;
  logic [XLEN-1:0]     branch_target;
  logic                halted;
  logic                illegal_op;

  modport master (
    output id_ex, id_ex_valid,
    input  stall, ex_mem, ex_mem_valid, branch_taken, branch_target,
           halted, illegal_op
  );

  modport slave (
    input  id_ex, id_ex_valid,
    output stall, ex_mem, ex_mem_valid, branch_taken, branch_target,
           halted, illegal_op
  );
endinterface

// File: rtl/ex_mul_iter.sv
// Shift-add multiplier, one multiplier bit per cycle, low half of product.
// Latency: start edge loads operands, CYCLES further edges iterate; done is high
// during the last iteration cycle with prod_lo already final. No backpressure.
// Ports: clock, reset_n (sync, active-low), start, a, b -> done, prod_lo.
module ex_mul_iter
  import fde_pkg::*;
#(
  parameter int W      = XLEN,
  parameter int CYCLES = MUL_CYCLES
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] prod_lo
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_next;
  logic [CW-1:0] cnt;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  // done is asserted on the final iteration so the consumer can register the
  // fully accumulated sum on that same edge.
  assign done     = (cnt == CW'(1));
  assign prod_lo  = acc_next;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(CYCLES);
    end else if (cnt != '0) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU/shift/branch in one cycle, iterative MUL, sticky HLT.
// Latency: 1 cycle for single-cycle ops, MUL result on the 32nd edge after accept.
// Backpressure: stall=1 while MUL_BUSY or HALTED; upstream holds id_ex stable.
// Ports: clock, reset_n (sync, active-low), bus (ex_stage_if.slave).
// Optional macro EX_ILLEGAL_CHK_EN: non-one-hot or bit15 op pulses illegal_op
// and halts; when undefined illegal_op is tied low and such ops act as NOP.
module ex_stage #(
  parameter int XLEN       = 32,
  parameter int EX_MEM_W   = 70,
  parameter int MUL_CYCLES = 32
) (
  input  logic       clock,
  input  logic       reset_n,
  ex_stage_if.slave  bus
);
  import fde_pkg::*;

  logic [XLEN-1:0] instr, pc, rs_v, rt_v, imm;
  logic [15:0]     op;
  logic [4:0]      rd, rt_idx, shamt;

  assign instr  = bus.id_ex[ID_INSTR_MSB:ID_INSTR_LSB];
  assign pc     = bus.id_ex[ID_PC_MSB:ID_PC_LSB];
  assign rs_v   = bus.id_ex[ID_RS_MSB:ID_RS_LSB];
  assign rt_v   = bus.id_ex[ID_RT_MSB:ID_RT_LSB];
  assign imm    = bus.id_ex[ID_IMM_MSB:ID_IMM_LSB];
  assign op     = bus.id_ex[ID_OP_MSB:ID_OP_LSB];
  assign rd     = instr[15:11];
  assign rt_idx = instr[20:16];
  assign shamt  = instr[10:6];

  ex_state_t           state;
  logic                stall_q, halted_q, exv_q, bt_q;
  logic [XLEN-1:0]     btgt_q;
  logic [EX_MEM_W-1:0] ex_mem_q;
  logic [4:0]          mul_dest;
  logic [XLEN-1:0]     mul_pc;

  logic            accept, legal, mul_start, mul_done;
  logic [XLEN-1:0] mul_prod, br_tgt;
  logic [XLEN-1:0] d_res;
  logic [4:0]      d_dest;
  logic            d_we, d_bt, d_halt, d_mul, d_ill;
  logic [EX_MEM_W-1:0] run_pkt, mul_pkt;

  // stall_q is a registered copy of (state != ST_RUN)
  assign accept = bus.id_ex_valid && !stall_q;
  assign legal  = $onehot(op[OP_NOP:OP_ADD]) && !op[OP_RSVD];
  assign br_tgt = pc + XLEN'(4) + (imm << 2);

  always_comb begin
    d_res  = '0;
    d_dest = '0;
    d_we   = 1'b0;
    d_bt   = 1'b0;
    d_halt = 1'b0;
    d_mul  = 1'b0;
    d_ill  = 1'b0;
    if (legal) begin
      if (op[OP_ADD])      begin d_res = rs_v + rt_v;     d_dest = rd;     d_we = 1'b1; end
      else if (op[OP_SUB]) begin d_res = rs_v - rt_v;     d_dest = rd;     d_we = 1'b1; end
      else if (op[OP_LI])  begin d_res = imm;             d_dest = rt_idx; d_we = 1'b1; end
      else if (op[OP_SHL]) begin d_res = rt_v << shamt;   d_dest = rd;     d_we = 1'b1; end
      else if (op[OP_SHR]) begin d_res = rt_v >> shamt;   d_dest = rd;     d_we = 1'b1; end
      else if (op[OP_AND]) begin d_res = rs_v & rt_v;     d_dest = rd;     d_we = 1'b1; end
      else if (op[OP_OR])  begin d_res = rs_v | rt_v;     d_dest = rd;     d_we = 1'b1; end
      else if (op[OP_XOR]) begin d_res = rs_v ^ rt_v;     d_dest = rd;     d_we = 1'b1; end
      else if (op[OP_MOV]) begin d_res = rs_v;            d_dest = rd;     d_we = 1'b1; end
      else if (op[OP_ADI]) begin d_res = rs_v + imm;      d_dest = rt_idx; d_we = 1'b1; end
      else if (op[OP_BR])  d_bt = 1'b1;
      else if (op[OP_BNE]) d_bt = (rs_v != rt_v);
      else if (op[OP_MUL]) d_mul = 1'b1;
      else if (op[OP_HLT]) d_halt = 1'b1;
      // OP_NOP: defaults
    end else begin
`ifdef EX_ILLEGAL_CHK_EN
      d_ill  = 1'b1;
      d_halt = 1'b1;
`endif
    end
  end

  always_comb begin
    run_pkt = '0;
    run_pkt[EXM_RES_MSB:EXM_RES_LSB]   = d_res;
    run_pkt[EXM_DEST_MSB:EXM_DEST_LSB] = d_dest;
    run_pkt[EXM_WE]                    = d_we;
    run_pkt[EXM_PC_MSB:EXM_PC_LSB]     = pc;
    mul_pkt = '0;
    mul_pkt[EXM_RES_MSB:EXM_RES_LSB]   = mul_prod;
    mul_pkt[EXM_DEST_MSB:EXM_DEST_LSB] = mul_dest;
    mul_pkt[EXM_WE]                    = 1'b1;
    mul_pkt[EXM_PC_MSB:EXM_PC_LSB]     = mul_pc;
  end

  assign mul_start = accept && d_mul;

  ex_mul_iter #(
    .W      (XLEN),
    .CYCLES (MUL_CYCLES)
  ) u_mul (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (rs_v),
    .b       (rt_v),
    .done    (mul_done),
    .prod_lo (mul_prod)
  );

`ifdef EX_ILLEGAL_CHK_EN
  logic ill_q;
  always_ff @(posedge clock) begin
    if (!reset_n) ill_q <= 1'b0;
    else          ill_q <= accept && d_ill;
  end
  assign bus.illegal_op = ill_q;
`else
  assign bus.illegal_op = 1'b0;
  logic unused_ill;
  assign unused_ill = d_ill;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= ST_RUN;
      stall_q  <= 1'b0;
      halted_q <= 1'b0;
      exv_q    <= 1'b0;
      bt_q     <= 1'b0;
      btgt_q   <= '0;
      ex_mem_q <= '0;
      mul_dest <= '0;
      mul_pc   <= '0;
    end else begin
      exv_q  <= 1'b0;
      bt_q   <= 1'b0;
      btgt_q <= '0;
      case (state)
        ST_RUN: begin
          if (accept) begin
            if (d_mul) begin
              state    <= ST_MUL_BUSY;
              stall_q  <= 1'b1;
              mul_dest <= rd;
              mul_pc   <= pc;
            end else begin
              ex_mem_q <= run_pkt;
              exv_q    <= 1'b1;
              bt_q     <= d_bt;
              btgt_q   <= d_bt ? br_tgt : '0;
              if (d_halt) begin
                state    <= ST_HALTED;
                stall_q  <= 1'b1;
                halted_q <= 1'b1;
              end
            end
          end
        end
        ST_MUL_BUSY: begin
          if (mul_done) begin
            ex_mem_q <= mul_pkt;
            exv_q    <= 1'b1;
            state    <= ST_RUN;
            stall_q  <= 1'b0;
          end
        end
        ST_HALTED: begin
          // sticky until reset
        end
        default: begin
          state   <= ST_RUN;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall         = stall_q;
  assign bus.halted        = halted_q;
  assign bus.ex_mem        = ex_mem_q;
  assign bus.ex_mem_valid  = exv_q;
  assign bus.branch_taken  = bt_q;
  assign bus.branch_target = btgt_q;
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the fetch/decode/execute pipeline.
- Consumes the 176-bit ID_EX packet produced by the decode stage and performs the ALU, shift, multiply or branch operation.
- Emits a registered EX_MEM packet for writeback, plus a branch redirect for fetch.
- An iterative multiplier and a sticky halt give it a stall handshake back upstream.

Parameters:
- XLEN, 32, datapath width.
- EX_MEM_W, 70, EX_MEM packet width.
- MUL_CYCLES, 32, multiply iterations, one bit per cycle.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  reset, synchronous, active-low
- id_ex  in  176  [31:0] instr, [63:32] PC, [95:64] rs value, [127:96] rt value, [159:128] sign-extended imm, [175:160] one-hot op
- id_ex_valid  in  1  packet present
- stall  out  1  upstream must hold id_ex stable; packet not accepted
- ex_mem  out  70  [31:0] result, [36:32] dest reg, [37] write enable, [69:38] PC
- ex_mem_valid  out  1  ex_mem holds a new result this cycle
- branch_taken  out  1  one-cycle redirect pulse
- branch_target  out  32  redirect PC
- halted  out  1  sticky halt
- illegal_op  out  1  illegal-op pulse (EX_ILLEGAL_CHK_EN only)

Behaviour:
- Clocking and reset: one clock (clock); reset is synchronous and active-low (reset_n). All state is updated on the rising edge.
- Reset values: all outputs 0, state RUN, multiplier cleared.
- Reset mid-operation: reset during MUL_BUSY or HALTED aborts the operation; the next cycle is RUN with stall=0.
- Accept rule: a packet is accepted when id_ex_valid && !stall.
- States:
  - RUN: stall=0.
  - MUL_BUSY: stall=1.
  - HALTED: stall=1.
- Single-cycle ops: result is registered on the accept edge, so ex_mem_valid is high the cycle after accept; latency 1. Back-to-back accepts are allowed.
- Op bit mapping and results (all arithmetic mod 2^32):
  - bit0 ADD: rs+rt, dest rd=instr[15:11].
  - bit1 SUB: rs-rt, dest rd.
  - bit2 LI: imm, dest rt=instr[20:16].
  - bit3 SHL: rt<<instr[10:6], logical, dest rd.
  - bit4 SHR: rt>>instr[10:6], logical, dest rd.
  - bit5/6/7 AND/OR/XOR: rs op rt, dest rd.
  - bit10 MOV: rs, dest rd.
  - bit11 ADI: rs+imm, dest rt.
- Write enable: we=1 for all result-producing ops; we=0 for BR, BNE, HLT and NOP.
- Branch target: PC + 4 + (imm<<2), 32-bit wrap.
  - bit8 BR: always taken.
  - bit9 BNE: taken iff rs != rt.
  - branch_taken and branch_target are valid in the same cycle as ex_mem_valid; branch_target is 0 when not taken.
- bit12 MUL:
  - Accept edge E0 moves the stage to MUL_BUSY.
  - Iterations run on edges E1..E32.
  - On E32 the low 32 bits of rs*rt are registered with dest rd, we=1, and the stage returns to RUN.
  - stall is high for exactly 32 cycles; the next accept is possible on E33.
- bit13 HLT: emits ex_mem_valid with we=0, enters HALTED; halted=1 and stall=1 until reset.
- bit14 NOP: ex_mem_valid=1, we=0.
- Bit 15, all-zero op or multiple bits set: treated as NOP unless EX_ILLEGAL_CHK_EN.
- ex_mem holds its last value when ex_mem_valid=0; ex_mem_valid, branch_taken and illegal_op are single-cycle pulses.

Optional Feature:
- Macro: EX_ILLEGAL_CHK_EN.
- Defined: an op field that is not exactly one-hot within bits [14:0], or has bit15 set, pulses illegal_op together with ex_mem_valid (we=0) and enters HALTED.
- Undefined: no illegal-op checker logic is built; illegal_op is tied to 0 and illegal ops behave as NOP.

Decomposition:
- Shared package fde_pkg holds:
  - ID_EX field bounds (INSTR, PC, RS, RT, IMM, OP ranges);
  - op bit indices OP_ADD..OP_NOP;
  - EX_MEM field bounds;
  - the state enum;
  - XLEN.
- The decoder is updated to import the same package.
- One sub-module, ex_mul_iter: shift-add multiplier with start, a MUL_CYCLES down-counter, done and a 32-bit product low half. It also clears on reset.

Test Plan:
- ADD, rs=AAAAAAAA rt=FFFFFFFF rd=5 -> next cycle result=AAAAAAA9, dest=5, we=1, ex_mem_valid=1.
- SHL, rt=66666666 shamt=4, then SHR of same by 4 back-to-back -> results 66666660 then 06666666 on consecutive cycles.
- BNE, rs=AAAAAAAA rt=FFFFFFFF PC=0x100 imm=FFFFFFFE -> branch_taken=1, target=0x000000FC, we=0. BNE with rs=rt -> branch_taken=0.
- MUL, rs=3 rt=0000000A with ADD held valid behind it -> stall high 32 cycles, result 0000001E; ADD accepted on E33. FFFFFFFF*FFFFFFFF -> 00000001.
- HLT followed by ADD held valid -> halted=1, stall=1, ADD never emitted; reset_n low one cycle -> halted=0, ADD accepted.
- Reset asserted at iteration 10 of MUL -> next cycle stall=0, ex_mem=0, no result emitted. With EX_ILLEGAL_CHK_EN, op=0x0003 -> illegal_op pulse, halted=1.
